// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FPU command sequencer.
package fpu_seq_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned RM_W    = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAG_W  = 9;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_HWR  = 3'd1;
    localparam logic [STATE_W-1:0] S_CLR  = 3'd2;
    localparam logic [STATE_W-1:0] S_RD   = 3'd3;
    localparam logic [STATE_W-1:0] S_LD   = 3'd4;
    localparam logic [STATE_W-1:0] S_EXEC = 3'd5;
    localparam logic [STATE_W-1:0] S_WB   = 3'd6;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV  = 3'd2;
    localparam logic [OP_W-1:0] OP_SQRT = 3'd3;
    localparam logic [OP_W-1:0] OP_CMP  = 3'd4;

    // Queued command word, op in the MSBs.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [RM_W-1:0]  rm;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    localparam int unsigned RSP_GREAT    = 0;
    localparam int unsigned RSP_EQ       = 1;
    localparam int unsigned RSP_LESS     = 2;
    localparam int unsigned RSP_DIV_ZERO = 3;
    localparam int unsigned RSP_INEXACT  = 4;
    localparam int unsigned RSP_INV      = 5;
    localparam int unsigned RSP_UN       = 6;
    localparam int unsigned RSP_OV       = 7;
    localparam int unsigned RSP_TIMEOUT  = 8;

endpackage

// File: rtl/fpu_seq_fifo.sv
// Synchronous FIFO with full/empty; simultaneous push and pop allowed when full.
module fpu_seq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstp,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Drives the FPU through clear/read/load/execute/writeback for each queued command.
// Define FPU_SEQ_PERF_EN to add the perf_retired / perf_busy_cyc counters.
module fpu_cmd_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYC  = 15,
    parameter int unsigned SCRATCH_ADDR = 31
) (
    input  logic        clk,
    input  logic        rstp,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [2:0]  cmd_rm,
    input  logic        host_wr_valid,
    output logic        host_wr_ready,
    input  logic [4:0]  host_wr_addr,
    input  logic [31:0] host_wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_rd,
    output logic [8:0]  rsp_flags,
    output logic [31:0] fpu_inp,
    output logic [4:0]  fpu_addr1,
    output logic [4:0]  fpu_addr2,
    output logic [4:0]  fpu_addr3,
    output logic [2:0]  fpu_opcode_in,
    output logic [2:0]  fpu_round_mp,
    output logic        fpu_enable,
    output logic        fpu_ld,
    input  logic        fpu_done,
    input  logic        fpu_ov,
    input  logic        fpu_un,
    input  logic        fpu_inv,
    input  logic        fpu_inexact,
    input  logic        fpu_div_zero,
    input  logic        fpu_less,
    input  logic        fpu_eq,
    input  logic        fpu_great,
`ifdef FPU_SEQ_PERF_EN
    output logic [15:0] perf_retired,
    output logic [31:0] perf_busy_cyc,
`endif
    output logic        busy
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [REG_W-1:0] SCRATCH = REG_W'(SCRATCH_ADDR);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    cmd_t               r_cmd;
    cmd_t               w_head;
    cmd_t               w_cmd_in;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_load_cmd;
    logic [TCNT_W-1:0]  r_tcnt;
    logic [TCNT_W-1:0]  w_tcnt_nxt;

    logic               r_rsp_valid;
    logic [REG_W-1:0]   r_rsp_rd;
    logic [FLAG_W-1:0]  r_rsp_flags;
    logic               w_rsp_set;
    logic [REG_W-1:0]   w_rsp_rd_nxt;
    logic [FLAG_W-1:0]  w_rsp_flags_nxt;

    logic               r_fpu_enable, w_fpu_enable_nxt;
    logic               r_fpu_ld, w_fpu_ld_nxt;
    logic [REG_W-1:0]   r_fpu_addr1, w_fpu_addr1_nxt;
    logic [REG_W-1:0]   r_fpu_addr2, w_fpu_addr2_nxt;
    logic [REG_W-1:0]   r_fpu_addr3, w_fpu_addr3_nxt;
    logic [DATA_W-1:0]  r_fpu_inp, w_fpu_inp_nxt;
    logic [OP_W-1:0]    r_fpu_opcode, w_fpu_opcode_nxt;
    logic [RM_W-1:0]    r_fpu_rm, w_fpu_rm_nxt;
    logic               r_host_wr_ready, w_host_wr_ready_nxt;

    assign w_cmd_in = {cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_rm};
    assign w_push   = cmd_valid && !w_fifo_full;

    fpu_seq_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstp    (rstp),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_cmd_in),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next state, FIFO pop, timeout count and response capture.
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_load_cmd      = 1'b0;
        w_tcnt_nxt      = r_tcnt;
        w_rsp_set       = 1'b0;
        w_rsp_rd_nxt    = r_cmd.rd;
        w_rsp_flags_nxt = '0;
        case (r_state)
            S_IDLE: begin
                w_tcnt_nxt = '0;
                if (host_wr_valid) begin
                    w_state_nxt = S_HWR;
                end else if (!w_fifo_empty && !r_rsp_valid) begin
                    w_pop = 1'b1;
                    if (w_head.op <= OP_CMP) begin
                        w_state_nxt = S_CLR;
                        w_load_cmd  = 1'b1;
                    end else begin
                        w_rsp_set                = 1'b1;
                        w_rsp_rd_nxt             = w_head.rd;
                        w_rsp_flags_nxt[RSP_INV] = 1'b1;
                    end
                end
            end
            S_HWR:  w_state_nxt = S_IDLE;
            S_CLR:  w_state_nxt = S_RD;
            S_RD:   w_state_nxt = S_LD;
            S_LD:   w_state_nxt = S_EXEC;
            S_EXEC: begin
                w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                // A done on the final allowed cycle takes precedence over the timeout.
                if (fpu_done) begin
                    w_state_nxt     = S_WB;
                    w_rsp_set       = 1'b1;
                    w_rsp_flags_nxt = {1'b0, fpu_ov, fpu_un, fpu_inv, fpu_inexact,
                                       fpu_div_zero, fpu_less, fpu_eq, fpu_great};
                end else if (w_tcnt_nxt == TCNT_W'(TIMEOUT_CYC)) begin
                    w_state_nxt                  = S_WB;
                    w_rsp_set                    = 1'b1;
                    w_rsp_flags_nxt[RSP_TIMEOUT] = 1'b1;
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
                w_tcnt_nxt  = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FPU pin values for the upcoming state; scratch entry absorbs idle writes.
    always_comb begin
        w_fpu_enable_nxt    = 1'b1;
        w_fpu_ld_nxt        = 1'b0;
        w_fpu_addr1_nxt     = '0;
        w_fpu_addr2_nxt     = '0;
        w_fpu_addr3_nxt     = SCRATCH;
        w_fpu_inp_nxt       = '0;
        w_fpu_opcode_nxt    = '0;
        w_fpu_rm_nxt        = '0;
        w_host_wr_ready_nxt = 1'b0;
        case (w_state_nxt)
            S_HWR: begin
                w_fpu_enable_nxt    = 1'b0;
                w_fpu_addr1_nxt     = host_wr_addr;
                w_fpu_inp_nxt       = host_wr_data;
                w_host_wr_ready_nxt = 1'b1;
            end
            S_CLR: begin
                w_fpu_enable_nxt = 1'b0;
                w_fpu_addr1_nxt  = SCRATCH;
            end
            S_RD, S_LD, S_EXEC, S_WB: begin
                w_fpu_addr1_nxt  = r_cmd.rs1;
                w_fpu_addr2_nxt  = r_cmd.rs2;
                w_fpu_opcode_nxt = r_cmd.op;
                w_fpu_rm_nxt     = r_cmd.rm;
                w_fpu_ld_nxt     = (w_state_nxt == S_LD);
                if (w_state_nxt == S_EXEC || w_state_nxt == S_WB) begin
                    w_fpu_addr3_nxt = r_cmd.rd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            r_state         <= S_IDLE;
            r_cmd           <= '0;
            r_tcnt          <= '0;
            r_fpu_enable    <= 1'b1;
            r_fpu_ld        <= 1'b0;
            r_fpu_addr1     <= '0;
            r_fpu_addr2     <= '0;
            r_fpu_addr3     <= SCRATCH;
            r_fpu_inp       <= '0;
            r_fpu_opcode    <= '0;
            r_fpu_rm        <= '0;
            r_host_wr_ready <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_tcnt          <= w_tcnt_nxt;
            if (w_load_cmd) r_cmd <= w_head;
            r_fpu_enable    <= w_fpu_enable_nxt;
            r_fpu_ld        <= w_fpu_ld_nxt;
            r_fpu_addr1     <= w_fpu_addr1_nxt;
            r_fpu_addr2     <= w_fpu_addr2_nxt;
            r_fpu_addr3     <= w_fpu_addr3_nxt;
            r_fpu_inp       <= w_fpu_inp_nxt;
            r_fpu_opcode    <= w_fpu_opcode_nxt;
            r_fpu_rm        <= w_fpu_rm_nxt;
            r_host_wr_ready <= w_host_wr_ready_nxt;
        end
    end

    // Response holds until consumed; a new one is only produced while empty.
    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rd    <= '0;
            r_rsp_flags <= '0;
        end else if (w_rsp_set) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rd    <= w_rsp_rd_nxt;
            r_rsp_flags <= w_rsp_flags_nxt;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef FPU_SEQ_PERF_EN
    logic [15:0] r_perf_retired;
    logic [31:0] r_perf_busy_cyc;

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            r_perf_retired  <= '0;
            r_perf_busy_cyc <= '0;
        end else begin
            if (w_rsp_set && (r_perf_retired != 16'hFFFF)) r_perf_retired <= r_perf_retired + 16'd1;
            if (r_state != S_IDLE) r_perf_busy_cyc <= r_perf_busy_cyc + 32'd1;
        end
    end

    assign perf_retired  = r_perf_retired;
    assign perf_busy_cyc = r_perf_busy_cyc;
`endif

    assign cmd_ready     = !w_fifo_full;
    assign host_wr_ready = r_host_wr_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rd        = r_rsp_rd;
    assign rsp_flags     = r_rsp_flags;
    assign fpu_inp       = r_fpu_inp;
    assign fpu_addr1     = r_fpu_addr1;
    assign fpu_addr2     = r_fpu_addr2;
    assign fpu_addr3     = r_fpu_addr3;
    assign fpu_opcode_in = r_fpu_opcode;
    assign fpu_round_mp  = r_fpu_rm;
    assign fpu_enable    = r_fpu_enable;
    assign fpu_ld        = r_fpu_ld;
    assign busy          = (r_state != S_IDLE) || !w_fifo_empty;

endmodule
